// File: rtl/mac_accumulator_if.sv
// Operand/result bundle for mac_accumulator.
// slave = accumulator side, master = producer/consumer side.
interface mac_accumulator_if #(
    parameter int MAC_WIDTH      = 36,
    parameter int SPECTRAL_BANDS = 100
);
    localparam int CW = $clog2(SPECTRAL_BANDS);

    logic [MAC_WIDTH-1:0] mac_in_1;
    logic [MAC_WIDTH-1:0] mac_in_2;
    logic                 mac_valid_in;
    logic                 mac_reset;
    logic [MAC_WIDTH-1:0] mac_out;
    logic                 mac_valid_out;
    logic                 mac_last;
    logic [CW-1:0]        band_count;
    logic                 overflow;
    logic                 operand_err;

    modport slave (
        input  mac_in_1,
        input  mac_in_2,
        input  mac_valid_in,
        input  mac_reset,
        output mac_out,
        output mac_valid_out,
        output mac_last,
        output band_count,
        output overflow,
        output operand_err
    );

    modport master (
        output mac_in_1,
        output mac_in_2,
        output mac_valid_in,
        output mac_reset,
        input  mac_out,
        input  mac_valid_out,
        input  mac_last,
        input  band_count,
        input  overflow,
        input  operand_err
    );
endinterface

// File: rtl/mac_accumulator.sv
// 2-stage signed multiply-accumulate over SPECTRAL_BANDS terms per pixel.
// Define MAC_SAT_EN to saturate the sum on overflow instead of wrapping.
module mac_accumulator #(
    parameter int SPECTRAL_BANDS = 100,
    parameter int WIDTH          = 16,
    parameter int MAC_WIDTH      = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    mac_accumulator_if.slave bus
);
    localparam int CW = $clog2(SPECTRAL_BANDS);
    localparam int PW = 2 * WIDTH;
    localparam int XW = MAC_WIDTH - WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(SPECTRAL_BANDS - 1);

    logic signed [WIDTH-1:0]     a_lo;
    logic signed [WIDTH-1:0]     b_lo;
    logic signed [PW-1:0]        a_x;
    logic signed [PW-1:0]        b_x;
    logic signed [PW-1:0]        prod;
    logic                        accept;
    logic                        a_bad;
    logic                        b_bad;

    logic [CW-1:0]               in_cnt_q;
    logic [CW-1:0]               in_cnt_d;
    logic                        s1_vld_q;
    logic signed [PW-1:0]        s1_prod_q;
    logic [CW-1:0]               s1_idx_q;
    logic                        s1_first;

    logic signed [MAC_WIDTH-1:0] acc_q;
    logic signed [MAC_WIDTH-1:0] acc_d;
    logic signed [MAC_WIDTH-1:0] base;
    logic signed [MAC_WIDTH-1:0] p_ext;
    logic signed [MAC_WIDTH-1:0] sum;
    logic                        add_ovf;
    logic                        ovf_q;
    logic                        ovf_d;
    logic [MAC_WIDTH-1:0]        out_q;
    logic                        vld_q;
    logic                        last_q;
    logic [CW-1:0]               band_q;
    logic                        operr_q;

    assign accept = bus.mac_valid_in & ~bus.mac_reset;
    assign a_lo   = bus.mac_in_1[WIDTH-1:0];
    assign b_lo   = bus.mac_in_2[WIDTH-1:0];
    assign a_x    = a_lo;
    assign b_x    = b_lo;
    assign prod   = a_x * b_x;
    assign a_bad  = bus.mac_in_1[MAC_WIDTH-1:WIDTH] != {XW{a_lo[WIDTH-1]}};
    assign b_bad  = bus.mac_in_2[MAC_WIDTH-1:WIDTH] != {XW{b_lo[WIDTH-1]}};

    assign in_cnt_d = (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_prod_q <= '0;
            s1_idx_q  <= '0;
        end else if (bus.mac_reset) begin
            in_cnt_q <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= bus.mac_valid_in;
            if (bus.mac_valid_in) begin
                s1_prod_q <= prod;
                s1_idx_q  <= in_cnt_q;
                in_cnt_q  <= in_cnt_d;
            end
        end
    end

    // Only rst_n clears the operand error; mac_reset leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operr_q <= 1'b0;
        end else if (accept && (a_bad || b_bad)) begin
            operr_q <= 1'b1;
        end
    end

    assign s1_first = (s1_idx_q == '0);
    assign p_ext    = s1_prod_q;

`ifdef MAC_SAT_EN
    localparam logic [MAC_WIDTH-1:0] SAT_MAX = {1'b0, {(MAC_WIDTH-1){1'b1}}};
    localparam logic [MAC_WIDTH-1:0] SAT_MIN = {1'b1, {(MAC_WIDTH-1){1'b0}}};

    logic clamp_q;
    logic clamp_d;

    always_comb begin
        base    = s1_first ? '0 : acc_q;
        sum     = base + p_ext;
        add_ovf = 1'b0;
        acc_d   = sum;
        clamp_d = s1_first ? 1'b0 : clamp_q;
        if (!s1_first && clamp_q) begin
            acc_d = acc_q;
        end else if ((base[MAC_WIDTH-1] == p_ext[MAC_WIDTH-1]) &&
                     (sum[MAC_WIDTH-1] != base[MAC_WIDTH-1])) begin
            add_ovf = 1'b1;
            clamp_d = 1'b1;
            acc_d   = base[MAC_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        ovf_d = s1_first ? add_ovf : (ovf_q | add_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clamp_q <= 1'b0;
        end else if (bus.mac_reset) begin
            clamp_q <= 1'b0;
        end else if (s1_vld_q) begin
            clamp_q <= clamp_d;
        end
    end
`else
    always_comb begin
        base    = s1_first ? '0 : acc_q;
        sum     = base + p_ext;
        acc_d   = sum;
        add_ovf = (base[MAC_WIDTH-1] == p_ext[MAC_WIDTH-1]) &&
                  (sum[MAC_WIDTH-1] != base[MAC_WIDTH-1]);
        ovf_d   = s1_first ? add_ovf : (ovf_q | add_ovf);
    end
`endif

    // mac_out survives mac_reset; the internal sum does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            band_q <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.mac_reset) begin
            acc_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            band_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= s1_vld_q;
            last_q <= s1_vld_q && (s1_idx_q == LAST_IDX);
            if (s1_vld_q) begin
                acc_q  <= acc_d;
                out_q  <= acc_d;
                band_q <= s1_idx_q;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.mac_out       = out_q;
    assign bus.mac_valid_out = vld_q;
    assign bus.mac_last      = last_q;
    assign bus.band_count    = band_q;
    assign bus.overflow      = ovf_q;
    assign bus.operand_err   = operr_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Random + directed bench for mac_accumulator against a group-sum reference model.
// A second 32-bit instance covers sum overflow (wrap or MAC_SAT_EN clamp).
module tb_mac_accumulator;
    localparam int SB = 4;
    localparam int W  = 16;
    localparam int MW = 36;
    localparam longint MAXV = (longint'(1) <<< (MW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (MW - 1));
    localparam longint MODV = longint'(1) <<< MW;

    typedef struct {
        int          due;
        logic [35:0] sum;
        int          idx;
        bit          last;
        bit          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_accumulator_if #(.MAC_WIDTH(MW), .SPECTRAL_BANDS(SB)) bus ();
    mac_accumulator_if #(.MAC_WIDTH(32), .SPECTRAL_BANDS(SB)) bus32 ();

    mac_accumulator #(.SPECTRAL_BANDS(SB), .WIDTH(W), .MAC_WIDTH(MW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    mac_accumulator #(.SPECTRAL_BANDS(SB), .WIDTH(W), .MAC_WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    exp_t        pend[$];
    logic [35:0] got[$];
    logic [31:0] got32[$];
    bit          ovf32[$];

    longint      g_sum;
    int          g_idx;
    bit          g_ovf;
    bit          g_clamp;
    logic [35:0] e_out;
    int          e_band;
    bit          e_ovf;
    bit          e_operr;
    bit          e_vld;
    bit          e_last;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    endtask

    function automatic bit is_bad(input logic [35:0] v);
        return v[35:16] != {20{v[15]}};
    endfunction

    function automatic logic [35:0] sx(input int v);
        logic [15:0] lo;
        lo = 16'(v);
        return {{20{lo[15]}}, lo};
    endfunction

    task automatic model_clear(input bit all);
        pend.delete();
        g_sum = 0; g_idx = 0; g_ovf = 0; g_clamp = 0;
        e_band = 0; e_ovf = 0;
        if (all) begin
            e_out = '0;
            e_operr = 0;
        end
    endtask

    task automatic model_term(input logic [35:0] a, input logic [35:0] b);
        logic [15:0] la, lb;
        longint p, ex;
        bit o;
        exp_t it;
        la = a[15:0];
        lb = b[15:0];
        p = longint'($signed(la)) * longint'($signed(lb));
        if (g_idx == 0) begin
            g_sum = 0; g_ovf = 0; g_clamp = 0;
        end
        ex = g_sum + p;
        o = (ex > MAXV) || (ex < MINV);
`ifdef MAC_SAT_EN
        if (g_clamp) begin
            ex = g_sum;
            o = 0;
        end else if (o) begin
            ex = (ex > MAXV) ? MAXV : MINV;
            g_clamp = 1;
        end
`else
        if (ex > MAXV) ex = ex - MODV;
        else if (ex < MINV) ex = ex + MODV;
`endif
        g_sum = ex;
        g_ovf = g_ovf | o;
        it.due = cyc + 1;
        it.sum = ex[35:0];
        it.idx = g_idx;
        it.last = (g_idx == SB - 1);
        it.ovf = g_ovf;
        pend.push_back(it);
        g_idx = (g_idx + 1) % SB;
    endtask

    task automatic tick(input bit v, input logic [35:0] a,
                        input logic [35:0] b, input bit mr);
        exp_t it;
        bus.mac_valid_in = v;   bus.mac_in_1 = a;
        bus.mac_in_2 = b;       bus.mac_reset = mr;
        bus32.mac_valid_in = v; bus32.mac_in_1 = a[31:0];
        bus32.mac_in_2 = b[31:0]; bus32.mac_reset = mr;
        @(posedge clk);
        cyc++;
        if (mr) begin
            model_clear(0);
        end else if (v) begin
            model_term(a, b);
            if (is_bad(a) || is_bad(b)) e_operr = 1;
        end
        @(negedge clk);
        e_vld = 0;
        e_last = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            it = pend.pop_front();
            e_vld = 1;
            e_last = it.last;
            e_out = it.sum;
            e_band = it.idx;
            e_ovf = it.ovf;
        end
        check("valid", 64'(bus.mac_valid_out), 64'(e_vld));
        check("last", 64'(bus.mac_last), 64'(e_last));
        check("out", 64'(bus.mac_out), 64'(e_out));
        check("band", 64'(bus.band_count), 64'(e_band));
        check("ovf", 64'(bus.overflow), 64'(e_ovf));
        check("operr", 64'(bus.operand_err), 64'(e_operr));
        if (bus.mac_valid_out) got.push_back(bus.mac_out);
        if (bus32.mac_valid_out) begin
            got32.push_back(bus32.mac_out);
            ovf32.push_back(bus32.overflow);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, '0, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out"}, 64'(bus.mac_out), 0);
        check({tag, "_vld"}, 64'(bus.mac_valid_out), 0);
        check({tag, "_last"}, 64'(bus.mac_last), 0);
        check({tag, "_band"}, 64'(bus.band_count), 0);
        check({tag, "_ovf"}, 64'(bus.overflow), 0);
        check({tag, "_operr"}, 64'(bus.operand_err), 0);
    endtask

    initial begin
        logic [35:0] a, b;
        bit v, mr;
        bus.mac_valid_in = 0; bus.mac_reset = 0;
        bus.mac_in_1 = '0;    bus.mac_in_2 = '0;
        bus32.mac_valid_in = 0; bus32.mac_reset = 0;
        bus32.mac_in_1 = '0;    bus32.mac_in_2 = '0;
        model_clear(1);
        #1;
        check_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // randomized stream with gaps, aborts and bad operands
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 29) == 0);
            a  = sx(int'($urandom()));
            b  = sx(int'($urandom()));
            if ($urandom_range(0, 31) == 0) a[35:16] = 20'($urandom());
            tick(v, a, b, mr);
        end

        // asynchronous reset mid-stream, between clock edges
        tick(1, sx(100), sx(-7), 0);
        #2 rst_n = 0;
        #1;
        check_zero("async");
        model_clear(1);
        bus.mac_valid_in = 0;
        bus32.mac_valid_in = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // bad upper bits: flagged, low bits (zero) still used
        got.delete();
        tick(1, 36'h0_0001_0000, sx(5), 0);
        idle(2);
        check("t6_operr", 64'(bus.operand_err), 1);
        check("t6_n", 64'(got.size()), 1);
        if (got.size() == 1) check("t6_sum", 64'(got[0]), 0);

        // back-to-back pixel then next pixel
        tick(0, '0, '0, 1);
        got.delete();
        tick(1, sx(3), sx(3), 0);
        tick(1, sx(-2), sx(-2), 0);
        tick(1, sx(5), sx(1), 0);
        tick(1, sx(0), sx(7), 0);
        tick(1, sx(1), sx(1), 0);
        idle(2);
        check("t2_n", 64'(got.size()), 5);
        if (got.size() == 5) begin
            check("t2_s0", 64'(got[0]), 9);
            check("t2_s1", 64'(got[1]), 13);
            check("t2_s2", 64'(got[2]), 18);
            check("t2_s3", 64'(got[3]), 18);
            check("t2_s4", 64'(got[4]), 1);
        end
        check("t2_band", 64'(bus.band_count), 0);

        // abort drops the in-flight and the presented term
        tick(0, '0, '0, 1);
        got.delete();
        tick(1, sx(1), sx(1), 0);
        tick(1, sx(1), sx(1), 0);
        tick(1, sx(7), sx(7), 1);
        tick(1, sx(2), sx(2), 0);
        idle(2);
        check("t3_n", 64'(got.size()), 2);
        if (got.size() == 2) begin
            check("t3_s0", 64'(got[0]), 1);
            check("t3_s1", 64'(got[1]), 4);
        end
        check("t3_band", 64'(bus.band_count), 0);

        // gaps mid-group
        tick(0, '0, '0, 1);
        got.delete();
        for (int c = 0; c < 12; c++) begin
            if (c == 0 || c == 3 || c == 4 || c == 9) tick(1, sx(1), sx(1), 0);
            else tick(0, '0, '0, 0);
        end
        check("t4_n", 64'(got.size()), 4);
        if (got.size() == 4) begin
            check("t4_s0", 64'(got[0]), 1);
            check("t4_s3", 64'(got[3]), 4);
        end

        // 32-bit sum overflow on the 2nd term
        tick(0, '0, '0, 1);
        got32.delete();
        ovf32.delete();
        for (int i = 0; i < 3; i++) tick(1, 36'h8000, 36'h8000, 0);
        idle(2);
        check("t5_n", 64'(got32.size()), 3);
        if (got32.size() == 3) begin
            check("t5_s0", 64'(got32[0]), 64'h4000_0000);
            check("t5_o0", 64'(ovf32[0]), 0);
            check("t5_o1", 64'(ovf32[1]), 1);
            check("t5_o2", 64'(ovf32[2]), 1);
`ifdef MAC_SAT_EN
            check("t5_s1", 64'(got32[1]), 64'h7FFF_FFFF);
            check("t5_s2", 64'(got32[2]), 64'h7FFF_FFFF);
`else
            check("t5_s1", 64'(got32[1]), 64'h8000_0000);
            check("t5_s2", 64'(got32[2]), 64'hC000_0000);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
